// File: rtl/dcache_dm_wb_if.sv
// CPU load/store request bus and memory-side line-transfer bus of the
// direct-mapped write-back data cache.
interface dcache_dm_wb_if;
  logic [31:0] cpu_raddr_i;
  logic        cpu_rreq_i;
  logic [31:0] cpu_waddr_i;
  logic [31:0] cpu_wdata_i;
  logic        cpu_wreq_i;
  logic [3:0]  cpu_wsel_i;
  logic [31:0] cpu_rdata_o;
  logic        stall_o;
  logic [31:0] mem_raddr_o;
  logic        mem_rreq_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] mem_waddr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_wreq_o;
  logic        mem_wready_i;

  modport slave (
    input  cpu_raddr_i, cpu_rreq_i, cpu_waddr_i,
    input  cpu_wdata_i, cpu_wreq_i, cpu_wsel_i,
    input  mem_rvalid_i, mem_rdata_i, mem_wready_i,
    output cpu_rdata_o, stall_o,
    output mem_raddr_o, mem_rreq_o,
    output mem_waddr_o, mem_wdata_o, mem_wreq_o
  );

  modport master (
    output cpu_raddr_i, cpu_rreq_i, cpu_waddr_i,
    output cpu_wdata_i, cpu_wreq_i, cpu_wsel_i,
    output mem_rvalid_i, mem_rdata_i, mem_wready_i,
    input  cpu_rdata_o, stall_o,
    input  mem_raddr_o, mem_rreq_o,
    input  mem_waddr_o, mem_wdata_o, mem_wreq_o
  );
endinterface

// File: rtl/dcache_dm_wb.sv
// Direct-mapped write-back write-allocate dcache, 16-byte lines.
// Define DCACHE_STATS_EN to add saturating hit/miss counters.
module dcache_dm_wb #(
  parameter int INDEX_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  dcache_dm_wb_if.slave  bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]    hit_cnt_o,
  output logic [31:0]    miss_cnt_o
`endif
);
  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 28 - INDEX_W;

  typedef enum logic [1:0] {
    S_IDLE, S_WB, S_REFILL, S_RESUME
  } state_t;

  state_t r_state, w_next;
  logic [1:0]         r_beat;
  logic [INDEX_W-1:0] r_midx;
  logic [TAG_W-1:0]   r_mtag, r_vtag;
  logic [LINES-1:0]   r_valid, r_dirty;
  logic [TAG_W-1:0]   r_tag  [LINES];
  logic [31:0]        r_data [LINES][4];

  logic [INDEX_W-1:0] w_ridx, w_widx, w_midx;
  logic [TAG_W-1:0]   w_rtag, w_wtag, w_mtag;
  logic [1:0]         w_rword, w_wword;
  logic w_rhit, w_whit, w_rmiss, w_wmiss, w_miss;
  logic w_done, w_wbeat, w_rbeat, w_fwd;
  logic [31:0] w_mask, w_old;
  logic w_unused_lsb;

  assign w_ridx  = bus.cpu_raddr_i[4 +: INDEX_W];
  assign w_widx  = bus.cpu_waddr_i[4 +: INDEX_W];
  assign w_rtag  = bus.cpu_raddr_i[31 -: TAG_W];
  assign w_wtag  = bus.cpu_waddr_i[31 -: TAG_W];
  assign w_rword = bus.cpu_raddr_i[3:2];
  assign w_wword = bus.cpu_waddr_i[3:2];
  assign w_unused_lsb = ^{bus.cpu_raddr_i[1:0], bus.cpu_waddr_i[1:0]};

  assign w_rhit  = r_valid[w_ridx] && (r_tag[w_ridx] == w_rtag);
  assign w_whit  = r_valid[w_widx] && (r_tag[w_widx] == w_wtag);
  assign w_rmiss = bus.cpu_rreq_i && !w_rhit;
  assign w_wmiss = bus.cpu_wreq_i && !w_whit;
  assign w_miss  = w_rmiss || w_wmiss;

  // Store miss is serviced before a load miss
  assign w_midx = w_wmiss ? w_widx : w_ridx;
  assign w_mtag = w_wmiss ? w_wtag : w_rtag;

  assign w_done  = (r_state == S_IDLE) && !w_miss;
  assign w_wbeat = (r_state == S_WB) && bus.mem_wready_i;
  assign w_rbeat = (r_state == S_REFILL) && bus.mem_rvalid_i;

  assign w_mask = {{8{bus.cpu_wsel_i[3]}}, {8{bus.cpu_wsel_i[2]}},
                   {8{bus.cpu_wsel_i[1]}}, {8{bus.cpu_wsel_i[0]}}};
  assign w_old  = r_data[w_ridx][w_rword];
  assign w_fwd  = bus.cpu_wreq_i && w_whit &&
                  (bus.cpu_raddr_i[31:2] == bus.cpu_waddr_i[31:2]);

  assign bus.cpu_rdata_o =
    !(bus.cpu_rreq_i && w_rhit) ? 32'h0 :
    w_fwd ? ((w_old & ~w_mask) | (bus.cpu_wdata_i & w_mask)) : w_old;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_beat  <= 2'd0;
      r_midx  <= '0;
      r_mtag  <= '0;
      r_vtag  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_miss) begin
        r_midx <= w_midx;
        r_mtag <= w_mtag;
        r_vtag <= r_tag[w_midx];
        r_beat <= 2'd0;
      end else if (w_wbeat || w_rbeat) begin
        r_beat <= r_beat + 2'd1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_miss)
          w_next = (r_valid[w_midx] && r_dirty[w_midx])
                   ? S_WB : S_REFILL;
      S_WB:
        if (w_wbeat && r_beat == 2'd3) w_next = S_REFILL;
      S_REFILL:
        if (w_rbeat && r_beat == 2'd3) w_next = S_RESUME;
      S_RESUME:
        w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.stall_o     = 1'b0;
    bus.mem_rreq_o  = 1'b0;
    bus.mem_wreq_o  = 1'b0;
    bus.mem_raddr_o = 32'h0;
    bus.mem_waddr_o = 32'h0;
    bus.mem_wdata_o = 32'h0;
    unique case (r_state)
      S_IDLE:
        bus.stall_o = w_miss && !rst;
      S_WB: begin
        bus.stall_o     = 1'b1;
        bus.mem_wreq_o  = 1'b1;
        bus.mem_waddr_o = {r_vtag, r_midx, r_beat, 2'b00};
        bus.mem_wdata_o = r_data[r_midx][r_beat];
      end
      S_REFILL: begin
        bus.stall_o     = 1'b1;
        bus.mem_rreq_o  = 1'b1;
        bus.mem_raddr_o = {r_mtag, r_midx, r_beat, 2'b00};
      end
      S_RESUME:
        bus.stall_o = 1'b1;
    endcase
  end

  // Line is invalid for the whole transfer so an abort never leaves it half-filled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if (r_state == S_IDLE && w_miss)
        r_valid[w_midx] <= 1'b0;
      if (w_done && bus.cpu_wreq_i)
        r_dirty[w_widx] <= 1'b1;
      if (w_rbeat && r_beat == 2'd3) begin
        r_valid[r_midx] <= 1'b1;
        r_dirty[r_midx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_rbeat) begin
      r_data[r_midx][r_beat] <= bus.mem_rdata_i;
      if (r_beat == 2'd3) r_tag[r_midx] <= r_mtag;
    end
    if (w_done && bus.cpu_wreq_i) begin
      for (int b = 0; b < 4; b++)
        if (bus.cpu_wsel_i[b])
          r_data[w_widx][w_wword][8*b +: 8] <= bus.cpu_wdata_i[8*b +: 8];
    end
  end

`ifdef DCACHE_STATS_EN
  logic [32:0] w_hsum, w_msum;
  assign w_hsum = {1'b0, hit_cnt_o} + 33'(bus.cpu_rreq_i)
                + 33'(bus.cpu_wreq_i);
  assign w_msum = {1'b0, miss_cnt_o} + 33'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_o  <= 32'h0;
      miss_cnt_o <= 32'h0;
    end else begin
      if (w_done)
        hit_cnt_o <= w_hsum[32] ? 32'hFFFF_FFFF : w_hsum[31:0];
      if (r_state == S_IDLE && w_miss)
        miss_cnt_o <= w_msum[32] ? 32'hFFFF_FFFF : w_msum[31:0];
    end
  end
`endif
endmodule

// File: doc/dcache_dm_wb.md
Name: dcache_dm_wb

Overview:
- Direct-mapped, write-back, write-allocate data cache directly downstream of the CPU core's dcache request port.
- Serves CPU loads and stores from an internal tag/data array.
- Stalls the CPU on a miss while it writes back a dirty victim and refills the line from the memory-side port.
- Line size is fixed at 16 bytes (4 × 32-bit words).

Parameters:
- INDEX_W, 8, index bits; line count = 2^INDEX_W. Address split: offset = addr[3:0], word = addr[3:2], index = addr[4+INDEX_W-1:4], tag = addr[31:4+INDEX_W].

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-high reset
cpu_raddr_i  in  32  load address
cpu_rreq_i  in  1  load request (level)
cpu_waddr_i  in  32  store address
cpu_wdata_i  in  32  store data
cpu_wreq_i  in  1  store request (level)
cpu_wsel_i  in  4  store byte enables, bit n = byte n
cpu_rdata_o  out  32  load data, combinational, valid when cpu_rreq_i=1 and stall_o=0
stall_o  out  1  CPU must hold all request inputs stable while high
mem_raddr_o  out  32  refill beat address (word-aligned)
mem_rreq_o  out  1  refill beat request
mem_rvalid_i  in  1  refill beat data valid
mem_rdata_i  in  32  refill beat data
mem_waddr_o  out  32  write-back beat address
mem_wdata_o  out  32  write-back beat data
mem_wreq_o  out  1  write-back beat request
mem_wready_i  in  1  write-back beat accepted

Behaviour:
- Reset (async, immediate): all valid and dirty bits cleared; state=IDLE. Outputs: stall_o=0, mem_rreq_o=0, mem_wreq_o=0, all address/data outputs 0, cpu_rdata_o=0. Data array is not reset. Reset mid-miss abandons the transfer; no partial line is left valid.
- Hit: valid[idx] && tag[idx]==addr tag.
  - Load hit: cpu_rdata_o driven combinationally in the same cycle.
  - Store hit: bytes with wsel=1 written at the next rising edge; dirty set.
  - Requests are level-sensitive: a store held high rewrites every cycle, which is harmless.
- Simultaneous load and store, both hits, same cycle:
  - Both complete.
  - If they target the same word, cpu_rdata_o returns the store-merged word (byte forwarding).
- Miss on either request: stall_o rises combinationally in the same cycle. Store miss is serviced before load miss.
- FSM states:
  - IDLE: no miss -> stay. Miss with victim valid && dirty -> WB. Otherwise -> REFILL.
  - WB: 4 beats, word 0..3, mem_waddr_o = {victim tag, idx, beat, 2'b00}.
    - Beat advances when mem_wreq_o && mem_wready_i.
    - After beat 3 accepted -> REFILL.
  - REFILL: 4 beats, mem_raddr_o = {req tag, idx, beat, 2'b00}.
    - mem_rreq_o is held until mem_rvalid_i; the word is written into the line on that edge.
    - After beat 3: valid=1, tag updated, dirty=0 -> RESUME.
  - RESUME: 1 cycle, stall_o still high. Re-evaluate and return to IDLE, where the now-hit request completes. A second outstanding miss (other request) starts a new WB/REFILL from IDLE.
- Stall timing: stall_o is high from the miss cycle through RESUME and low in the IDLE cycle where the hit completes.
- Handshake rules: mem_wreq_o and mem_rreq_o are never high together. Beat counter is 2 bits and wraps 3->0 at sequence end.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined: adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0], both reset to 0.
  - hit_cnt_o increments once per completed access in IDLE, counting load and store separately; both in one cycle adds 2.
  - miss_cnt_o increments once per IDLE->WB/REFILL transition.
  - Both saturate at 32'hFFFFFFFF.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Cold store+load: store 0x0000ABCD to 0x00000010, wsel=4'hF.
  - Expect one refill of 4 beats at 0x10..0x1C, stall 6+ cycles.
  - Then load 0x10 returns 0x0000ABCD with no stall.
- Sequential hit sweep: 16 lines, addr {20'b0, i[7:0], 4'b0}, data random < 0xFFFF; write then read each.
  - Every read matches.
  - No WB beats, since no evictions.
- Dirty eviction: store 0x11111111 at 0x00000020, then store at 0x00001020 (same index, new tag).
  - Expect 4 WB beats with mem_waddr_o 0x20..0x2C, first mem_wdata_o=0x11111111, then refill at 0x1020.
- Byte merge: line holds 0xAABBCCDD at 0x30; store wsel=4'b0101 data 0x11223344 -> load returns 0xAA22CC44. The same value is forwarded when the load and store are issued in the same cycle.
- Backpressure: mem_wready_i and mem_rvalid_i held low 5 cycles per beat.
  - Addresses and data stay stable, stall_o stays high.
  - Final data is correct.
- Reset mid-refill: assert rst during beat 2.
  - All outputs are 0 immediately.
  - Subsequent load to the same address misses and refills fully.
